// File: rtl/encrypt_if.sv
// encrypt_if: handshake, operand and result bundle for encrypt_core.
// The master drives enable/start/operands; the slave returns ciphertext, busy and done.
interface encrypt_if;
   logic                              enable;
   logic                              start;
   logic signed [1:0][1:0][3:0][31:0] public_a;
   logic signed [1:0][3:0][31:0]      public_t;
   logic signed [1:0][3:0][31:0]      rand_r;
   logic signed [1:0][3:0][31:0]      noise_e1;
   logic signed [3:0][31:0]           noise_e2;
   logic [3:0]                        message;
   logic signed [1:0][1:0][3:0][31:0] ciphertext;
   logic                              busy;
   logic                              done;

   modport master (
      output enable, start, public_a, public_t, rand_r, noise_e1, noise_e2, message,
      input  ciphertext, busy, done
   );

   modport slave (
      input  enable, start, public_a, public_t, rand_r, noise_e1, noise_e2, message,
      output ciphertext, busy, done
   );
endinterface

// File: rtl/encrypt_core.sv
// encrypt_core: small module-lattice encryption over Z_Q[x]/(x^4+1), rank 2.
// One negacyclic polynomial product per MAC cycle (six in total), then a
// FINAL cycle adds noise and the scaled message and reduces mod Q.
// Optional feature: define ENCRYPT_NOISE_EN to add e1/e2 in FINAL; otherwise
// the noise ports are present but ignored.
module encrypt_core #(
   parameter int Q     = 17,
   parameter int DELTA = 9
) (
   input  logic     clk,
   input  logic     rst_n,
   encrypt_if.slave bus
);

   typedef logic [3:0][31:0]           poly_t;
   typedef logic [1:0][1:0][3:0][31:0] ct_t;
   typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;

   state_t     state;
   logic [2:0] step;
   logic       busy_q;
   logic       done_q;
   poly_t      u0_acc, u1_acc, v_acc;
   ct_t        ct_q;

   logic [1:0][1:0][3:0][31:0] a_q;
   logic [1:0][3:0][31:0]      t_q, r_q;
   logic [3:0]                 msg_q;
`ifdef ENCRYPT_NOISE_EN
   logic [1:0][3:0][31:0]      e1_q;
   poly_t                      e2_q;
`else
   logic                       unused_noise;
   assign unused_noise = ^{bus.noise_e1, bus.noise_e2};
`endif

   poly_t op_a, op_b, prod;
   ct_t   fin_ct;
   logic  accept;

   // Negacyclic product: x^4 wraps to -1, plain signed 32-bit arithmetic.
   function automatic poly_t nc_mul(input poly_t a, input poly_t b);
      logic signed [31:0] c [4];
      logic signed [31:0] p;
      poly_t              res;
      for (int k = 0; k < 4; k++) c[k] = 32'sd0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            p = $signed(a[i]) * $signed(b[j]);
            if (i + j < 4) c[2'(i + j)] = c[2'(i + j)] + p;
            else           c[2'(i + j)] = c[2'(i + j)] - p;
         end
      end
      for (int k = 0; k < 4; k++) res[k] = c[k];
      return res;
   endfunction

   function automatic poly_t padd(input poly_t a, input poly_t b);
      poly_t res;
      for (int k = 0; k < 4; k++) res[k] = $signed(a[k]) + $signed(b[k]);
      return res;
   endfunction

   // Least non-negative residue; % keeps the dividend's sign, so fold negatives up.
   function automatic logic [31:0] mod_q(input logic signed [31:0] x);
      logic signed [31:0] r;
      r = x % Q;
      if (r < 0) r = r + Q;
      return r;
   endfunction

   assign accept = bus.enable && (state == IDLE) && bus.start && !done_q;

   // Operand selection for the current MAC step.
   always_comb begin
      op_a = '0;
      op_b = '0;
      case (step)
         3'd0: begin op_a = a_q[0][0]; op_b = r_q[0]; end
         3'd1: begin op_a = a_q[1][0]; op_b = r_q[1]; end
         3'd2: begin op_a = a_q[0][1]; op_b = r_q[0]; end
         3'd3: begin op_a = a_q[1][1]; op_b = r_q[1]; end
         3'd4: begin op_a = t_q[0];    op_b = r_q[0]; end
         3'd5: begin op_a = t_q[1];    op_b = r_q[1]; end
         default: ;
      endcase
      prod = nc_mul(op_a, op_b);
   end

   // FINAL-cycle result: add noise and scaled message, reduce mod Q.
   always_comb begin
      logic signed [31:0] n0, n1, n2;
      fin_ct = '0;
      for (int i = 0; i < 4; i++) begin
`ifdef ENCRYPT_NOISE_EN
         n0 = $signed(e1_q[0][i]);
         n1 = $signed(e1_q[1][i]);
         n2 = $signed(e2_q[i]);
`else
         n0 = 32'sd0;
         n1 = 32'sd0;
         n2 = 32'sd0;
`endif
         fin_ct[0][0][i] = mod_q($signed(u0_acc[i]) + n0);
         fin_ct[0][1][i] = mod_q($signed(u1_acc[i]) + n1);
         fin_ct[1][0][i] = mod_q($signed(v_acc[i]) + n2 + (msg_q[i] ? DELTA : 0));
      end
   end

   // Operand capture on an accepted start; free to change afterwards.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= bus.public_a;
         t_q   <= bus.public_t;
         r_q   <= bus.rand_r;
         msg_q <= bus.message;
`ifdef ENCRYPT_NOISE_EN
         e1_q  <= bus.noise_e1;
         e2_q  <= bus.noise_e2;
`endif
      end
   end

   // Control FSM with accumulators, registered busy/done and ciphertext.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         step   <= 3'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         u0_acc <= '0;
         u1_acc <= '0;
         v_acc  <= '0;
         ct_q   <= '0;
      end else if (bus.enable) begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  u0_acc <= '0;
                  u1_acc <= '0;
                  v_acc  <= '0;
                  step   <= 3'd0;
                  busy_q <= 1'b1;
                  state  <= MAC;
               end
            end
            MAC: begin
               case (step)
                  3'd0, 3'd1: u0_acc <= padd(u0_acc, prod);
                  3'd2, 3'd3: u1_acc <= padd(u1_acc, prod);
                  default:    v_acc  <= padd(v_acc, prod);
               endcase
               if (step == 3'd5) state <= FINAL;
               else              step  <= step + 3'd1;
            end
            FINAL: begin
               ct_q   <= fin_ct;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               step   <= 3'd0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ciphertext = ct_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_encrypt_core.sv
// tb_encrypt_core: directed vectors with hand-computed ciphertexts for encrypt_core.
module tb_encrypt_core;

   typedef logic [3:0][31:0]           poly_t;
   typedef logic [1:0][1:0][3:0][31:0] ct_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   lat, bcnt, ndone, first_done;
   ct_t  held;

   always #5 clk = ~clk;

   encrypt_if bus ();

   encrypt_core #(.Q(17), .DELTA(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic poly_t pl(input int c0, input int c1, input int c2, input int c3);
      poly_t p;
      p[0] = c0; p[1] = c1; p[2] = c2; p[3] = c3;
      return p;
   endfunction

   function automatic ct_t mk(input poly_t u0, input poly_t u1, input poly_t v);
      ct_t c = '0;
      c[0][0] = u0; c[0][1] = u1; c[1][0] = v;
      return c;
   endfunction

   task automatic chk_ct(input string tag, input ct_t obs, input ct_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.enable   = 1'b1;
      bus.start    = 1'b0;
      bus.public_a = '0;
      bus.public_t = '0;
      bus.rand_r   = '0;
      bus.noise_e1 = '0;
      bus.noise_e2 = '0;
      bus.message  = 4'b0000;
   endtask

   // Pulse start for one edge; lat = cycle index (1 = cycle after the start edge) of done.
   task automatic run_op(output int l, output int b);
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      l = 1; b = 0;
      if (bus.busy) b++;
      while (!bus.done && l < 40) begin
         @(negedge clk);
         l++;
         if (bus.busy) b++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      #12;
      chk_ct ("reset_ct",   bus.ciphertext, '0);
      chk_int("reset_busy", int'(bus.busy), 0);
      chk_int("reset_done", int'(bus.done), 0);
      @(negedge clk); rst_n = 1'b1;

      // Message only
      bus.message = 4'b1010;
      run_op(lat, bcnt);
      chk_int("msg_latency", lat, 8);
      chk_int("msg_busy_cycles", bcnt, 7);
      chk_ct ("msg_ct", bus.ciphertext, mk('0, '0, pl(0, 9, 0, 9)));
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      chk_int("done_pulse_width", int'(bus.done), 0);
      chk_int("start_in_done_ignored", int'(bus.busy), 0);

      // Negacyclic wrap: x^3 * x = -1
      clear_inputs();
      bus.public_a[0][0] = pl(0, 0, 0, 1);
      bus.rand_r[0]      = pl(0, 1, 0, 0);
      run_op(lat, bcnt);
      chk_ct("wrap_ct", bus.ciphertext, mk(pl(16, 0, 0, 0), '0, '0));
      held = bus.ciphertext;
      bus.public_a = '1;
      bus.message  = 4'b1111;
      repeat (5) @(negedge clk);
      chk_ct("ct_hold", bus.ciphertext, held);

      // r1 path: u0=(1+2x)(1+x^3), u1=3x^2(1+x^3), v=2(1+x^3)+msg
      clear_inputs();
      bus.public_a[0][0] = pl(5, 5, 5, 5);
      bus.public_a[1][0] = pl(1, 2, 0, 0);
      bus.public_a[1][1] = pl(0, 0, 3, 0);
      bus.public_t[0]    = pl(4, 4, 4, 4);
      bus.public_t[1]    = pl(2, 0, 0, 0);
      bus.rand_r[1]      = pl(1, 0, 0, 1);
      bus.message        = 4'b0001;
      run_op(lat, bcnt);
      chk_ct("r1_ct", bus.ciphertext, mk(pl(16, 2, 0, 1), pl(0, 14, 3, 0), pl(11, 0, 0, 2)));

      // r0 path with a sum above Q
      clear_inputs();
      bus.public_a[0][0] = pl(1, 1, 1, 1);
      bus.public_a[0][1] = pl(0, 1, 0, 0);
      bus.public_a[1][0] = pl(7, 7, 7, 7);
      bus.public_a[1][1] = pl(7, 7, 7, 7);
      bus.public_t[0]    = pl(16, 0, 0, 0);
      bus.public_t[1]    = pl(7, 7, 7, 7);
      bus.rand_r[0]      = pl(2, 0, 0, 0);
      run_op(lat, bcnt);
      chk_ct("r0_ct", bus.ciphertext, mk(pl(2, 2, 2, 2), pl(0, 2, 0, 0), pl(15, 0, 0, 0)));

      // Negative randomness, all message bits set
      clear_inputs();
      bus.public_t[0] = pl(0, 0, 5, 0);
      bus.rand_r[0]   = pl(-2, 0, 0, 0);
      bus.message     = 4'b1111;
      run_op(lat, bcnt);
      chk_ct("neg_r_ct", bus.ciphertext, mk('0, '0, pl(9, 9, 16, 9)));

      // Noise terms
      clear_inputs();
      bus.noise_e1[0] = pl(-2, 0, 0, 0);
      bus.noise_e1[1] = pl(0, 3, 0, 0);
      bus.noise_e2    = pl(-1, 0, 0, 0);
      run_op(lat, bcnt);
`ifdef ENCRYPT_NOISE_EN
      chk_ct("noise_ct", bus.ciphertext, mk(pl(15, 0, 0, 0), pl(0, 3, 0, 0), pl(16, 0, 0, 0)));
`else
      chk_ct("noise_ct", bus.ciphertext, mk('0, '0, '0));
`endif

      // Second start during MAC is dropped
      clear_inputs();
      bus.message = 4'b1010;
      @(negedge clk); bus.start = 1'b1;
      ndone = 0; first_done = 0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         @(negedge clk);
         bus.start = (cyc == 3);
         if (bus.done) begin
            ndone++;
            if (first_done == 0) first_done = cyc;
         end
      end
      bus.start = 1'b0;
      chk_int("restart_done_count", ndone, 1);
      chk_int("restart_latency", first_done, 8);
      chk_ct ("restart_ct", bus.ciphertext, mk('0, '0, pl(0, 9, 0, 9)));

      // Enable low for three cycles in MAC
      clear_inputs();
      bus.message = 4'b0101;
      @(negedge clk); bus.start = 1'b1;
      ndone = 0; first_done = 0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         @(negedge clk);
         bus.start  = 1'b0;
         bus.enable = !(cyc >= 2 && cyc <= 4);
         if (bus.done) begin
            ndone++;
            if (first_done == 0) first_done = cyc;
         end
      end
      bus.enable = 1'b1;
      chk_int("stall_done_count", ndone, 1);
      chk_int("stall_latency", first_done, 11);
      chk_ct ("stall_ct", bus.ciphertext, mk('0, '0, pl(9, 0, 9, 0)));

      // Reset during MAC step 3
      clear_inputs();
      bus.message = 4'b1111;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_int("midreset_busy", int'(bus.busy), 0);
      chk_int("midreset_done", int'(bus.done), 0);
      chk_ct ("midreset_ct", bus.ciphertext, '0);
      @(negedge clk); rst_n = 1'b1;
      bus.message = 4'b1010;
      run_op(lat, bcnt);
      chk_int("post_reset_latency", lat, 8);
      chk_ct ("post_reset_ct", bus.ciphertext, mk('0, '0, pl(0, 9, 0, 9)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
